// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the video timing pipeline.
// Holds the default SVGA 800x600@56 raster constants, the line/frame total
// helpers and the colour-channel expansion function used by the output stage.
package video_timing_pkg;

  // Default SVGA 800x600@56 timing.
  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 24;
  localparam int unsigned SVGA_H_SYNC   = 72;
  localparam int unsigned SVGA_H_BP     = 128;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 2;
  localparam int unsigned SVGA_V_BP     = 22;

  function automatic int unsigned calc_h_total(int unsigned active, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned calc_v_total(int unsigned active, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Replicate the low `width` bits of value MSB-first, truncated to 8 bits.
  // Each pass shifts in the next source bit, so the first one lands in bit 7.
  function automatic logic [7:0] expand_color(logic [7:0] value, int unsigned width);
    logic [7:0]  res;
    logic [7:0]  sh;
    int unsigned idx;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = width - 1 - (i % width);
      sh  = value >> idx;
      res = {res[6:0], sh[0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Fixed-depth register delay line with clock enable and async reset.
// Ports: i_clk clock, i_rst async active-high reset, i_en stage enable,
//        i_d input word, o_q word delayed by DEPTH enabled cycles.
// DEPTH = 0 degenerates to a plain wire.
module vid_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst, i_en};
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_en) begin
        r_stage[0] <= i_d;
        for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_pipe.sv
// Parametrised raster timing generator with renderer-latency alignment and
// SDL-style output register.
// Ports: pixel_clk / sim_rst (async, active high) / en (whole-pipeline stall);
//        h_coord, v_coord, disp_enbl: raw stage-0 position to the renderer;
//        red/green/blue: renderer colour, RENDER_LAT cycles after stage 0;
//        sdl_sx/sy/de/r/g/b, h_sync, v_sync, frame_start, frame_cnt: aligned
//        outputs, RENDER_LAT+1 cycles after stage 0.
module video_timing_pipe
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = SVGA_H_ACTIVE,
  parameter int unsigned H_FP       = SVGA_H_FP,
  parameter int unsigned H_SYNC     = SVGA_H_SYNC,
  parameter int unsigned H_BP       = SVGA_H_BP,
  parameter int unsigned V_ACTIVE   = SVGA_V_ACTIVE,
  parameter int unsigned V_FP       = SVGA_V_FP,
  parameter int unsigned V_SYNC     = SVGA_V_SYNC,
  parameter int unsigned V_BP       = SVGA_V_BP,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned RENDER_LAT = 0,
  parameter int unsigned H_W        = 11,
  parameter int unsigned V_W        = 10,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic               pixel_clk,
  input  logic               sim_rst,
  input  logic               en,
  output logic [H_W-1:0]     h_coord,
  output logic [V_W-1:0]     v_coord,
  output logic               disp_enbl,
  input  logic [COLOR_W-1:0] red,
  input  logic [COLOR_W-1:0] green,
  input  logic [COLOR_W-1:0] blue,
  output logic [H_W-1:0]     sdl_sx,
  output logic [V_W-1:0]     sdl_sy,
  output logic               sdl_de,
  output logic [7:0]         sdl_r,
  output logic [7:0]         sdl_g,
  output logic [7:0]         sdl_b,
  output logic               h_sync,
  output logic               v_sync,
  output logic               frame_start,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 2 ** H_W) begin : g_chk_hw
    $error("H_TOTAL does not fit in H_W");
  end
  if (V_TOTAL > 2 ** V_W) begin : g_chk_vw
    $error("V_TOTAL does not fit in V_W");
  end
  if (COLOR_W < 1 || COLOR_W > 8) begin : g_chk_cw
    $error("COLOR_W must be in 1..8");
  end
  if (RENDER_LAT > 8) begin : g_chk_lat
    $error("RENDER_LAT must be in 0..8");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_chk_porch
    $error("porch and sync widths must be at least 1");
  end

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam int unsigned    DL_W       = H_W + V_W + 4;

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;

  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (en) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + V_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + H_W'(1);
      end
    end
  end

  // Stage 0: combinational decode of the counters.
  logic w_de, w_hs_act, w_vs_act, w_sof;
  assign w_de     = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign w_hs_act = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_vs_act = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  assign w_sof    = (r_h_cnt == '0) && (r_v_cnt == '0);

  assign h_coord   = r_h_cnt;
  assign v_coord   = r_v_cnt;
  assign disp_enbl = w_de;

  // Match the renderer latency so position and flags meet their colour.
  logic [DL_W-1:0] w_dl_d, w_dl_q;
  logic [H_W-1:0]  w_dl_h;
  logic [V_W-1:0]  w_dl_v;
  logic            w_dl_de, w_dl_hs, w_dl_vs, w_dl_sof;

  assign w_dl_d = {r_h_cnt, r_v_cnt, w_de, w_hs_act, w_vs_act, w_sof};
  assign {w_dl_h, w_dl_v, w_dl_de, w_dl_hs, w_dl_vs, w_dl_sof} = w_dl_q;

  vid_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (RENDER_LAT)
  ) u_delay (
    .i_clk (pixel_clk),
    .i_rst (sim_rst),
    .i_en  (en),
    .i_d   (w_dl_d),
    .o_q   (w_dl_q)
  );

  logic [7:0] w_r_exp, w_g_exp, w_b_exp;
  assign w_r_exp = expand_color(8'(red), COLOR_W);
  assign w_g_exp = expand_color(8'(green), COLOR_W);
  assign w_b_exp = expand_color(8'(blue), COLOR_W);

  logic [H_W-1:0]    r_sx;
  logic [V_W-1:0]    r_sy;
  logic              r_de, r_hs, r_vs, r_fs;
  logic [7:0]        r_r, r_g, r_b;
  logic [FCNT_W-1:0] r_fcnt;

  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_de   <= 1'b0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_hs   <= ~H_SYNC_POL;
      r_vs   <= ~V_SYNC_POL;
      r_fs   <= 1'b0;
      r_fcnt <= '0;
    end else if (en) begin
      r_sx <= w_dl_h;
      r_sy <= w_dl_v;
      r_de <= w_dl_de;
      r_r  <= w_dl_de ? w_r_exp : 8'h00;
      r_g  <= w_dl_de ? w_g_exp : 8'h00;
      r_b  <= w_dl_de ? w_b_exp : 8'h00;
      r_hs <= w_dl_hs ? H_SYNC_POL : ~H_SYNC_POL;
      r_vs <= w_dl_vs ? V_SYNC_POL : ~V_SYNC_POL;
      r_fs <= w_dl_sof;
      if (w_dl_sof) r_fcnt <= r_fcnt + FCNT_W'(1);
    end
  end

  assign sdl_sx      = r_sx;
  assign sdl_sy      = r_sy;
  assign sdl_de      = r_de;
  assign sdl_r       = r_r;
  assign sdl_g       = r_g;
  assign sdl_b       = r_b;
  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign frame_start = r_fs;
  assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_video_timing_pipe.sv
// Directed bench for video_timing_pipe. Uses a reduced raster (24 x 12) so
// whole frames fit in a short run. dut0: RENDER_LAT=0, 4-bit frame counter,
// fixed colour. dut3: RENDER_LAT=3, active-low h_sync, renderer model
// returning h_coord[3:0] three cycles late.
module tb_video_timing_pipe;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = 24;
  localparam int VA = 8, VF = 1, VS = 2, VB = 1, VT = 12;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ecyc     = 0;  // enabled clock edges since reset release

  // dut0
  logic [10:0] h0, sx0;
  logic [9:0]  v0, sy0;
  logic        dr0, de0, hs0, vs0, fs0;
  logic [7:0]  r0, g0, b0;
  logic [3:0]  fc0;
  logic [3:0]  red0, grn0, blu0;
  assign red0 = 4'hA;
  assign grn0 = 4'h3;
  assign blu0 = 4'hF;

  // dut3
  logic [10:0] h3, sx3;
  logic [9:0]  v3, sy3;
  logic        dr3, de3, hs3, vs3, fs3;
  logic [7:0]  r3, g3, b3;
  logic [15:0] fc3;
  logic [3:0]  red3, grn3, blu3;
  logic [3:0]  rp1, rp2, rp3;
  assign red3 = rp3;
  assign grn3 = 4'h5;
  assign blu3 = 4'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rp1 <= '0;
      rp2 <= '0;
      rp3 <= '0;
    end else if (en) begin
      rp1 <= h3[3:0];
      rp2 <= rp1;
      rp3 <= rp2;
    end
  end

  video_timing_pipe #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1),
    .COLOR_W (4), .RENDER_LAT (0), .H_W (11), .V_W (10), .FCNT_W (4)
  ) dut0 (
    .pixel_clk (clk), .sim_rst (rst), .en (en),
    .h_coord (h0), .v_coord (v0), .disp_enbl (dr0),
    .red (red0), .green (grn0), .blue (blu0),
    .sdl_sx (sx0), .sdl_sy (sy0), .sdl_de (de0),
    .sdl_r (r0), .sdl_g (g0), .sdl_b (b0),
    .h_sync (hs0), .v_sync (vs0), .frame_start (fs0), .frame_cnt (fc0)
  );

  video_timing_pipe #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b1),
    .COLOR_W (4), .RENDER_LAT (3), .H_W (11), .V_W (10), .FCNT_W (16)
  ) dut3 (
    .pixel_clk (clk), .sim_rst (rst), .en (en),
    .h_coord (h3), .v_coord (v3), .disp_enbl (dr3),
    .red (red3), .green (grn3), .blue (blu3),
    .sdl_sx (sx3), .sdl_sy (sy3), .sdl_de (de3),
    .sdl_r (r3), .sdl_g (g3), .sdl_b (b3),
    .h_sync (hs3), .v_sync (vs3), .frame_start (fs3), .frame_cnt (fc3)
  );

  logic [52:0] obs0;
  logic [64:0] obs3;
  assign obs0 = {sx0, sy0, de0, hs0, vs0, fs0, fc0, r0, g0, b0};
  assign obs3 = {sx3, sy3, de3, hs3, vs3, fs3, fc3, r3, g3, b3};

  // Reference raster model; p is the stage-0 index the outputs should carry
  // (negative means nothing has reached the output register yet).
  function automatic int px(int p);
    return (p < 0) ? 0 : p % HT;
  endfunction
  function automatic int py(int p);
    return (p < 0) ? 0 : (p / HT) % VT;
  endfunction
  function automatic bit ede(int p);
    return (p >= 0) && (px(p) < HA) && (py(p) < VA);
  endfunction
  function automatic bit ehs(int p);
    return (p >= 0) && (px(p) >= HA + HF) && (px(p) < HA + HF + HS);
  endfunction
  function automatic bit evs(int p);
    return (p >= 0) && (py(p) >= VA + VF) && (py(p) < VA + VF + VS);
  endfunction
  function automatic bit efs(int p);
    return (p >= 0) && (p % FRAME == 0);
  endfunction
  function automatic int efc(int p);
    return (p < 0) ? 0 : p / FRAME + 1;
  endfunction

  function automatic logic [52:0] exp0(int p);
    logic d;
    d = ede(p);
    return {11'(px(p)), 10'(py(p)), d, ehs(p), evs(p), efs(p), 4'(efc(p)),
            d ? 8'hAA : 8'h00, d ? 8'h33 : 8'h00, d ? 8'hFF : 8'h00};
  endfunction

  function automatic logic [64:0] exp3(int p);
    logic       d;
    logic [3:0] x4;
    d  = ede(p);
    x4 = 4'(px(p));
    return {11'(px(p)), 10'(py(p)), d, !ehs(p), evs(p), efs(p), 16'(efc(p)),
            d ? {x4, x4} : 8'h00, d ? 8'h55 : 8'h00, 8'h00};
  endfunction

  function automatic logic [21:0] exp_raw(int p);
    return {11'(px(p)), 10'(py(p)), ede(p)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (en) ecyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) step();
    n_checks++;
    if (obs0 !== exp0(-1)) $display("FAIL reset_dut0: got %h expected %h", obs0, exp0(-1));
    else n_pass++;
    n_checks++;
    if (obs3 !== exp3(-1)) $display("FAIL reset_dut3: got %h expected %h", obs3, exp3(-1));
    else n_pass++;
    n_checks++;
    if ({h0, v0, dr0} !== {11'd0, 10'd0, 1'b1})
      $display("FAIL reset_stage0: got %h/%h/%b expected 0/0/1", h0, v0, dr0);
    else n_pass++;
    rst  = 1'b0;
    ecyc = 0;
    n_checks++;
    if ({de0, fs0, de3, fs3} !== 4'b0000)
      $display("FAIL cycle0_flags: got %b expected 0000", {de0, fs0, de3, fs3});
    else n_pass++;
  endtask

  task automatic test_first_pixel();
    step();
    n_checks++;
    if ({fs0, sx0, sy0, de0, fc0} !== {1'b1, 11'd0, 10'd0, 1'b1, 4'd1})
      $display("FAIL first_pixel: got fs=%b sx=%0d sy=%0d de=%b fc=%0d expected 1 0 0 1 1",
               fs0, sx0, sy0, de0, fc0);
    else n_pass++;
    n_checks++;
    if ({r0, g0, b0} !== 24'hAA33FF)
      $display("FAIL colour_expand: got %h%h%h expected aa33ff", r0, g0, b0);
    else n_pass++;
    for (int k = 2; k <= 4; k++) begin
      n_checks++;
      if (fs3 !== 1'b0) $display("FAIL lat3_early_fs: cycle %0d got %b expected 0", k - 1, fs3);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({fs3, de3, sx3, sy3, fc3} !== {1'b1, 1'b1, 11'd0, 10'd0, 16'd1})
      $display("FAIL lat3_first_pixel: got fs=%b de=%b sx=%0d sy=%0d fc=%0d expected 1 1 0 0 1",
               fs3, de3, sx3, sy3, fc3);
    else n_pass++;
  endtask

  task automatic test_line();
    for (int i = 0; i < HT + 3; i++) begin
      step();
      n_checks++;
      if (obs0 !== exp0(ecyc - 1))
        $display("FAIL line_dut0: ecyc %0d got %h expected %h", ecyc, obs0, exp0(ecyc - 1));
      else n_pass++;
      n_checks++;
      if (obs3 !== exp3(ecyc - 4))
        $display("FAIL line_dut3: ecyc %0d got %h expected %h", ecyc, obs3, exp3(ecyc - 4));
      else n_pass++;
      n_checks++;
      if ({h0, v0, dr0} !== exp_raw(ecyc))
        $display("FAIL line_stage0: ecyc %0d got %h expected %h", ecyc, {h0, v0, dr0},
                 exp_raw(ecyc));
      else n_pass++;
    end
  endtask

  task automatic test_frame_wrap();
    int last_fs = -1;
    int n_fs    = 0;
    for (int i = 0; i < FRAME * 16 + 4; i++) begin
      step();
      n_checks++;
      if (obs0 !== exp0(ecyc - 1))
        $display("FAIL frame_dut0: ecyc %0d got %h expected %h", ecyc, obs0, exp0(ecyc - 1));
      else n_pass++;
      n_checks++;
      if (obs3 !== exp3(ecyc - 4))
        $display("FAIL frame_dut3: ecyc %0d got %h expected %h", ecyc, obs3, exp3(ecyc - 4));
      else n_pass++;
      if (fs0 === 1'b1) begin
        n_fs++;
        if (last_fs >= 0) begin
          n_checks++;
          if (ecyc - last_fs !== FRAME)
            $display("FAIL frame_period: got %0d expected %0d", ecyc - last_fs, FRAME);
          else n_pass++;
        end
        last_fs = ecyc;
      end
    end
    n_checks++;
    if (n_fs !== 16) $display("FAIL frame_start_count: got %0d expected 16", n_fs);
    else n_pass++;
  endtask

  task automatic test_stall();
    int guard = 0;
    while (px(ecyc - 1) != 5 && guard < HT + 1) begin
      step();
      guard++;
    end
    n_checks++;
    if (px(ecyc - 1) != 5) $display("FAIL stall_setup: bound expired at ecyc %0d", ecyc);
    else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (obs0 !== exp0(ecyc - 1))
        $display("FAIL stall_dut0: got %h expected %h", obs0, exp0(ecyc - 1));
      else n_pass++;
      n_checks++;
      if (obs3 !== exp3(ecyc - 4))
        $display("FAIL stall_dut3: got %h expected %h", obs3, exp3(ecyc - 4));
      else n_pass++;
      n_checks++;
      if ({h0, v0, dr0} !== exp_raw(ecyc))
        $display("FAIL stall_stage0: got %h expected %h", {h0, v0, dr0}, exp_raw(ecyc));
      else n_pass++;
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (obs0 !== exp0(ecyc - 1))
        $display("FAIL resume_dut0: got %h expected %h", obs0, exp0(ecyc - 1));
      else n_pass++;
      n_checks++;
      if (obs3 !== exp3(ecyc - 4))
        $display("FAIL resume_dut3: got %h expected %h", obs3, exp3(ecyc - 4));
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(px(ecyc - 1) == 10 && py(ecyc - 1) == 5) && guard < FRAME + 1) begin
      step();
      guard++;
    end
    n_checks++;
    if ({sx0, sy0} !== {11'd10, 10'd5})
      $display("FAIL midrst_setup: got (%0d,%0d) expected (10,5)", sx0, sy0);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs0 !== exp0(-1)) $display("FAIL midrst_dut0: got %h expected %h", obs0, exp0(-1));
    else n_pass++;
    n_checks++;
    if (obs3 !== exp3(-1)) $display("FAIL midrst_dut3: got %h expected %h", obs3, exp3(-1));
    else n_pass++;
    n_checks++;
    if ({h0, v0} !== 21'd0) $display("FAIL midrst_stage0: got %h/%h expected 0/0", h0, v0);
    else n_pass++;
    @(negedge clk);
    rst  = 1'b0;
    ecyc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (obs0 !== exp0(ecyc - 1))
        $display("FAIL restart_dut0: ecyc %0d got %h expected %h", ecyc, obs0, exp0(ecyc - 1));
      else n_pass++;
      n_checks++;
      if (obs3 !== exp3(ecyc - 4))
        $display("FAIL restart_dut3: ecyc %0d got %h expected %h", ecyc, obs3, exp3(ecyc - 4));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line();
    test_frame_wrap();
    test_stall();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
